// File: rtl/reg_write_sequencer_pkg.sv
// Shared definitions for the register-bank write sequencer: default widths,
// debounce length and the FSM state encoding.
package reg_write_sequencer_pkg;

  localparam int ADDR_W_DEF          = 4;
  localparam int DATA_W_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DB_PRESS = 3'd1;
  localparam logic [2:0] ST_WRITE    = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_DB_REL   = 3'd4;

  // Counter width for the stable-sample counter; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/reg_write_sequencer_btn_debounce.sv
// Two-flop synchronisers for the button and switches, plus the saturating
// stable-sample counter that the sequencer FSM restarts on every bounce.
module btn_debounce
  import reg_write_sequencer_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [ADDR_W-1:0] addr_raw,
  input  logic [DATA_W-1:0] data_raw,
  input  logic              restart,
  output logic              btn_s,
  output logic [ADDR_W-1:0] addr_s,
  output logic [DATA_W-1:0] data_s,
  output logic              stable
);

  localparam int                SYNC_W   = 1 + ADDR_W + DATA_W;
  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_W-1:0] meta_r;
  logic [SYNC_W-1:0] sync_r;
  logic [CNT_W-1:0]  cnt_r;

  // Two-stage synchroniser for every asynchronous input bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= {btn_raw, addr_raw, data_raw};
      sync_r <= meta_r;
    end
  end

  // Stable-sample counter; holds at the compare value instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign btn_s  = sync_r[SYNC_W-1];
  assign addr_s = sync_r[DATA_W +: ADDR_W];
  assign data_s = sync_r[DATA_W-1:0];
  assign stable = (cnt_r == CNT_LAST);

endmodule

// File: rtl/reg_write_sequencer.sv
// Write-side front end of the 16x4 register bank: one RegWrite strobe per clean
// button press. Define AUTO_INC_EN to take addrW from an internal wrapping pointer.
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_write,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic [ADDR_W-1:0] addrW,
  output logic [DATA_W-1:0] datW,
  output logic              RegWrite,
  output logic              busy
);

  logic [2:0]        state_r;
  logic [2:0]        next_s;
  logic              restart_s;
  logic              btn_s;
  logic              stable_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;
  logic [ADDR_W-1:0] capture_addr_s;
  logic              capture_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              regwrite_r;
  logic              busy_r;

  btn_debounce #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_write),
    .addr_raw (sw_addr),
    .data_raw (sw_data),
    .restart  (restart_s),
    .btn_s    (btn_s),
    .addr_s   (addr_s),
    .data_s   (data_s),
    .stable   (stable_s)
  );

  // Next-state logic; the counter only runs while a level is being qualified.
  always_comb begin
    next_s    = state_r;
    restart_s = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (btn_s) next_s = ST_DB_PRESS;
        else       next_s = ST_IDLE;
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          next_s = ST_IDLE;
        end else if (stable_s) begin
          next_s = ST_WRITE;
        end else begin
          next_s    = ST_DB_PRESS;
          restart_s = 1'b0;
        end
      end
      ST_WRITE: begin
        next_s = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (btn_s) next_s = ST_WAIT_REL;
        else       next_s = ST_DB_REL;
      end
      ST_DB_REL: begin
        if (btn_s) begin
          next_s = ST_DB_REL;
        end else if (stable_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s    = ST_DB_REL;
          restart_s = 1'b0;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  assign capture_s = (state_r == ST_DB_PRESS) && (next_s == ST_WRITE);

`ifdef AUTO_INC_EN
  logic [ADDR_W-1:0] ptr_r;

  // Write pointer advances in the cycle after each strobe, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (state_r == ST_WRITE) begin
      ptr_r <= ptr_r + ADDR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign capture_addr_s = ptr_r;
`else
  assign capture_addr_s = addr_s;
`endif

  // State register plus registered strobe, busy and captured address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      regwrite_r <= 1'b0;
      busy_r     <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
    end else begin
      state_r    <= next_s;
      regwrite_r <= (next_s == ST_WRITE);
      busy_r     <= (next_s != ST_IDLE);
      if (capture_s) begin
        addr_r <= capture_addr_s;
        data_r <= data_s;
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  assign addrW    = addr_r;
  assign datW     = data_r;
  assign RegWrite = regwrite_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Randomised and directed bench for reg_write_sequencer (DEBOUNCE_CYCLES=4),
// compared each cycle against a sample-run reference model.
module tb_reg_write_sequencer;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_write;
  logic [3:0] sw_addr;
  logic [3:0] sw_data;
  logic [3:0] addrW;
  logic [3:0] datW;
  logic       RegWrite;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int dut_strobes = 0;

  // Reference model: raw inputs reach the control logic two edges late.
  bit         d1_b, d2_b;
  logic [3:0] d1_a, d2_a, d1_d, d2_d;
  int         phase, run;
  logic [3:0] m_addr, m_data, ptr;
  bit         m_we, m_busy;

  reg_write_sequencer #(
    .ADDR_W          (4),
    .DATA_W          (4),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_write (btn_write),
    .sw_addr   (sw_addr),
    .sw_data   (sw_data),
    .addrW     (addrW),
    .datW      (datW),
    .RegWrite  (RegWrite),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    d1_b = 0; d2_b = 0; d1_a = '0; d2_a = '0; d1_d = '0; d2_d = '0;
    phase = 0; run = 0; m_addr = '0; m_data = '0; ptr = '0;
    m_we = 0; m_busy = 0;
  endtask

  // phase 0: waiting for DC+1 consecutive high samples; 1: strobe cycle;
  // 2: waiting for first low sample; 3: needs DC low samples since entry/last high.
  task automatic model_edge();
    bit x;
    logic [3:0] a, d;
    x = d2_b; a = d2_a; d = d2_d;
    d2_b = d1_b; d2_a = d1_a; d2_d = d1_d;
    d1_b = btn_write; d1_a = sw_addr; d1_d = sw_data;
    m_we = 0;
    case (phase)
      0: begin
        if (x) begin
          run++;
          if (run == DC + 1) begin
            phase = 1; run = 0; m_we = 1; m_data = d;
`ifdef AUTO_INC_EN
            m_addr = ptr;
`else
            m_addr = a;
`endif
          end
        end else begin
          run = 0;
        end
      end
      1: begin
        phase = 2;
        ptr = ptr + 4'd1;
      end
      2: if (!x) begin phase = 3; run = 0; end
      3: begin
        if (x) run = 0;
        else   run++;
        if (run == DC) begin phase = 0; run = 0; end
      end
      default: phase = 0;
    endcase
    m_busy = (phase != 0) || (run > 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check("RegWrite", RegWrite, m_we);
    check("busy", busy, m_busy);
    check("addrW", addrW, m_addr);
    check("datW", datW, m_data);
    if (RegWrite) dut_strobes++;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_RegWrite"}, RegWrite, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_addrW"}, addrW, 4'h0);
    check({tag, "_datW"}, datW, 4'h0);
  endtask

  initial begin
    int first;
    int n;
    rst = 1'b1;
    btn_write = 1'($urandom_range(0, 1));
    sw_addr = 4'($urandom);
    sw_data = 4'($urandom);
    model_reset();

    // 1: asynchronous reset with random inputs
    #3 rst = 1'b0;
    #1 check_zero_outputs("reset");
    for (int i = 0; i < 3; i++) begin
      btn_write = 1'($urandom_range(0, 1));
      sw_addr = 4'($urandom);
      sw_data = 4'($urandom);
      cycle();
    end
    btn_write = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // 2: clean press, latency and capture
    sw_addr = 4'hA; sw_data = 4'h5; btn_write = 1'b1;
    dut_strobes = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (RegWrite && first < 0) first = i;
    end
    check("press_latency", first, 7);
    check("press_count", dut_strobes, 1);
`ifdef AUTO_INC_EN
    check("press_addr", addrW, 4'h0);
`else
    check("press_addr", addrW, 4'hA);
`endif
    check("press_data", datW, 4'h5);
    sw_addr = 4'h3; sw_data = 4'hC; btn_write = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    check("hold_data_after_sw_change", datW, 4'h5);

    // 3: short bounce is rejected
    dut_strobes = 0;
    btn_write = 1'b1; cycle();
    btn_write = 1'b0; cycle();
    btn_write = 1'b1; cycle();
    btn_write = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    check("bounce_count", dut_strobes, 0);
    check("bounce_idle", busy, 1'b0);

    // 4: long hold, release with two bounces
    dut_strobes = 0;
    sw_addr = 4'h7; sw_data = 4'h9; btn_write = 1'b1;
    for (int i = 0; i < 100; i++) cycle();
    btn_write = 1'b0; cycle();
    btn_write = 1'b1; cycle();
    btn_write = 1'b0; cycle();
    btn_write = 1'b1; cycle();
    btn_write = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (busy && n == i - 1) n = i;
    end
    check("release_busy_cycles", n + 1, 2 + DC);
    check("hold_count", dut_strobes, 1);

    // 5: reset during DB_PRESS, button still held
    dut_strobes = 0;
    sw_addr = 4'h2; sw_data = 4'hE; btn_write = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    #1 rst = 1'b0;
    #1 check_zero_outputs("midrst");
    model_reset();
    cycle();
    rst = 1'b1;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (RegWrite && first < 0) first = i;
    end
    check("midrst_latency", first, 7);
    check("midrst_count", dut_strobes, 1);
    btn_write = 1'b0;
    for (int i = 0; i < 15; i++) cycle();

    // random presses with bounces and moving switches
    for (int k = 0; k < 40; k++) begin
      sw_addr = 4'($urandom);
      sw_data = 4'($urandom);
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        btn_write = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 3) == 0) sw_data = 4'($urandom);
        cycle();
      end
      btn_write = 1'b0;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) cycle();
    end
    for (int i = 0; i < 12; i++) cycle();

`ifdef AUTO_INC_EN
    // 6: pointer sequence across 17 presses, wrapping after 15
    #1 rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
    for (int k = 0; k < 17; k++) begin
      sw_data = 4'(k % 16);
      sw_addr = 4'($urandom);
      btn_write = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (RegWrite) begin
          check("auto_addr", addrW, k % 16);
          check("auto_data", datW, k % 16);
          n++;
        end
      end
      check("auto_count", n, 1);
      btn_write = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
